// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: ramps duty and inserts brake dead-time on reversal for a tb6612fng.
// Optional command watchdog is built when MOTOR_WATCHDOG_EN is defined.
module motor_cmd_sequencer #(
    parameter int unsigned RAMP_DIV     = 1000,
    parameter int unsigned RAMP_STEP    = 4,
    parameter int unsigned DEADTIME_CYC = 1000,
    parameter int unsigned WDT_CYC      = 10_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_i,
    output logic        ctrl_we_o,
    output logic [31:0] ctrl_o,
    output logic [1:0]  state_o,
    output logic        busy_o,
    output logic        wdt_trip_o
);

    localparam int unsigned   PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned   DW         = $clog2(DEADTIME_CYC + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DT_LOAD    = DW'(DEADTIME_CYC);
    localparam logic [7:0]    STEP       = 8'(RAMP_STEP);
    localparam logic [1:0]    DIR_BRAKE  = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_RAMPDN = 2'd1,
        ST_BRAKE  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    dir_q, dir_d;
    logic [7:0]    duty_q, duty_d;
    logic [DW-1:0] dt_q, dt_d;
    logic [PW-1:0] presc_q;
    logic [1:0]    tgt_dir_q;
    logic [7:0]    tgt_duty_q;
    logic          tick;
    logic          wdt_expire;
    logic [7:0]    gap_up, gap_dn;
    logic          cmd_unused;

    assign cmd_unused = ^{cmd_i[31:18], cmd_i[15:8]};

    function automatic logic is_drive(input logic [1:0] d);
        return d[0] ^ d[1];
    endfunction

    assign tick   = (presc_q == PRESC_LAST);
    assign gap_up = tgt_duty_q - duty_q;
    assign gap_dn = duty_q - tgt_duty_q;

`ifdef MOTOR_WATCHDOG_EN
    localparam int unsigned   WW       = (WDT_CYC > 1) ? $clog2(WDT_CYC + 1) : 1;
    localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYC - 1);
    localparam logic [WW-1:0] WDT_SAT  = WW'(WDT_CYC);

    logic [WW-1:0] wdt_q;
    logic          wdt_trip_q;

    // Counter saturates after expiry so the target is forced to stop only once.
    assign wdt_expire = !cmd_we_i && (wdt_q == WDT_LAST);
    assign wdt_trip_o = wdt_trip_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_q      <= '0;
            wdt_trip_q <= 1'b0;
        end else if (cmd_we_i) begin
            wdt_q      <= '0;
            wdt_trip_q <= 1'b0;
        end else if (wdt_q != WDT_SAT) begin
            wdt_q <= wdt_q + 1'b1;
            if (wdt_expire) wdt_trip_q <= 1'b1;
        end
    end
`else
    localparam int unsigned WDT_unused = WDT_CYC;
    assign wdt_expire = 1'b0;
    assign wdt_trip_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tgt_dir_q  <= '0;
            tgt_duty_q <= '0;
        end else if (cmd_we_i) begin
            tgt_dir_q  <= cmd_i[17:16];
            tgt_duty_q <= cmd_i[7:0];
        end else if (wdt_expire) begin
            tgt_dir_q  <= '0;
            tgt_duty_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        dt_d    = dt_q;
        unique case (state_q)
            ST_RUN: begin
                if (tgt_dir_q == dir_q) begin
                    if (is_drive(dir_q) && tick) begin
                        if (tgt_duty_q > duty_q)
                            duty_d = (gap_up > STEP) ? duty_q + STEP : tgt_duty_q;
                        else if (tgt_duty_q < duty_q)
                            duty_d = (gap_dn > STEP) ? duty_q - STEP : tgt_duty_q;
                    end
                end else if (!is_drive(dir_q)) begin
                    dir_d = tgt_dir_q;
                end else begin
                    state_d = ST_RAMPDN;
                end
            end
            ST_RAMPDN: begin
                if (tgt_dir_q == dir_q) begin
                    state_d = ST_RUN;
                end else if (duty_q == '0) begin
                    if (is_drive(tgt_dir_q)) begin
                        state_d = ST_BRAKE;
                        dir_d   = DIR_BRAKE;
                        dt_d    = DT_LOAD;
                    end else begin
                        state_d = ST_RUN;
                        dir_d   = tgt_dir_q;
                    end
                end else if (tick) begin
                    duty_d = (duty_q > STEP) ? duty_q - STEP : '0;
                end
            end
            ST_BRAKE: begin
                if (dt_q <= DW'(1)) begin
                    dt_d    = '0;
                    state_d = ST_RUN;
                    dir_d   = tgt_dir_q;
                end else begin
                    dt_d = dt_q - 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            dir_q     <= '0;
            duty_q    <= '0;
            dt_q      <= '0;
            presc_q   <= '0;
            ctrl_we_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            duty_q    <= duty_d;
            dt_q      <= dt_d;
            presc_q   <= tick ? '0 : presc_q + 1'b1;
            ctrl_we_o <= ({dir_d, duty_d} != {dir_q, duty_q});
        end
    end

    // ctrl_o is a direct flop image, so the strobe lands in the cycle it changes.
    assign ctrl_o  = {14'b0, dir_q, 8'b0, duty_q};
    assign state_o = state_q;
    assign busy_o  = (state_q != ST_RUN) || (duty_q != tgt_duty_q);

endmodule

// File: doc/motor_cmd_sequencer.md
MOTOR_CMD_SEQUENCER -- requirements
Module: motor_cmd_sequencer

Interface
REQ-001 SHALL have parameter RAMP_DIV, default 1000: clock cycles per ramp tick (>=1).
REQ-002 SHALL have parameter RAMP_STEP, default 4: maximum duty change per ramp tick (1..255).
REQ-003 SHALL have parameter DEADTIME_CYC, default 1000: brake hold cycles on a direction reversal (>=1).
REQ-004 SHALL have parameter WDT_CYC, default 10_000_000: command-silence cycles before watchdog trip.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port cmd_we_i, input, 1 bit: one-cycle CPU MMIO write strobe for the motor command.
REQ-008 SHALL have port cmd_i, input, 32 bits: bits 17:16 are the direction code and bits 7:0 are the duty; other bits are ignored.
REQ-009 SHALL have port ctrl_we_o, output, 1 bit: write strobe to the tb6612fng we_i.
REQ-010 SHALL have port ctrl_o, output, 32 bits: {14'b0, cur_dir[1:0], 8'b0, cur_duty[7:0]} to the tb6612fng ctrl_i.
REQ-011 SHALL have port state_o, output, 2 bits: 0 RUN, 1 RAMPDN, 2 BRAKE.
REQ-012 SHALL have port busy_o, output, 1 bit: high when state != RUN or cur_duty != tgt_duty.
REQ-013 SHALL have port wdt_trip_o, output, 1 bit: sticky watchdog-tripped flag.

Function
REQ-014 SHALL encode direction as 00 stop, 01 forward, 10 reverse, 11 brake; "drive" means 01 or 10.
REQ-015 SHALL latch tgt_dir and tgt_duty from cmd_i on cmd_we_i; the new target is used from the next cycle.
REQ-016 SHALL generate a ramp tick from a prescaler counting 0..RAMP_DIV-1 that wraps, with the tick on the terminal count; the prescaler runs freely in every state.
REQ-017 In RUN with tgt_dir == cur_dir, on each tick, cur_duty SHALL move toward tgt_duty by min(RAMP_STEP, |tgt_duty-cur_duty|) with 8-bit unsigned arithmetic, never overshooting and never wrapping.
REQ-018 In RUN, if cur_dir is 00 or 11 and tgt_dir is a drive code, the block SHALL set cur_dir to tgt_dir in one cycle with duty still 0, then ramp up per REQ-017.
REQ-019 In RUN, if tgt_dir != cur_dir and cur_dir is a drive code, the block SHALL enter RAMPDN on the next cycle.
REQ-020 In RAMPDN, on each tick, cur_duty SHALL decrease by min(RAMP_STEP, cur_duty).
REQ-021 When cur_duty reaches 0 in RAMPDN and tgt_dir is the opposite drive code, the block SHALL enter BRAKE, set cur_dir to 11, and load the dead-time counter with DEADTIME_CYC.
REQ-022 When cur_duty reaches 0 in RAMPDN and tgt_dir is 00 or 11, the block SHALL set cur_dir to tgt_dir and return to RUN with duty held at 0; tgt_duty is ignored for codes 00 and 11.
REQ-023 In RAMPDN, if tgt_dir becomes equal to cur_dir again, the block SHALL return to RUN on the next cycle and ramp from the present cur_duty.
REQ-024 In BRAKE, the counter SHALL decrement each cycle; on reaching 0 the block SHALL set cur_dir to the latest tgt_dir, keep duty at 0, and enter RUN.
REQ-025 A command received during BRAKE SHALL only update the target; BRAKE SHALL never be exited early.
REQ-026 ctrl_o SHALL be registered; ctrl_we_o SHALL pulse high for exactly the one cycle in which ctrl_o takes a new value, and at no other time.
REQ-027 If cmd_we_i and a tick occur in the same cycle, the tick SHALL use the old target.

Reset
REQ-028 While rst_ni is low, the block SHALL immediately clear cur_dir, cur_duty, tgt_dir, tgt_duty, the prescaler, the dead-time counter, the watchdog counter, ctrl_o, ctrl_we_o and wdt_trip_o, and SHALL force state to RUN.
REQ-029 After reset is released, no ctrl_we_o pulse SHALL occur until a command changes ctrl_o.
REQ-030 A reset asserted mid-ramp or mid-BRAKE SHALL abort the operation with no further ctrl_we_o pulse.

Configuration
REQ-031 With macro MOTOR_WATCHDOG_EN defined, a counter cleared by cmd_we_i SHALL count cycles, and on reaching WDT_CYC the block SHALL set the target to {00, 0} and set wdt_trip_o; wdt_trip_o SHALL clear on the next cmd_we_i.
REQ-032 With MOTOR_WATCHDOG_EN defined, if cmd_we_i coincides with expiry, the command SHALL win and wdt_trip_o SHALL remain 0.
REQ-033 Without MOTOR_WATCHDOG_EN, the block SHALL contain no watchdog counter and SHALL tie wdt_trip_o to 0.

Verification (bench parameters: RAMP_DIV=4, RAMP_STEP=16, DEADTIME_CYC=8, WDT_CYC=200)
REQ-034 The bench SHALL cover: reset, then cmd 0x0001_0040 -> cur_dir 01, then duty 16, 32, 48, 64 on successive ticks, 5 ctrl_we_o pulses, then busy_o low.
REQ-035 The bench SHALL cover: at forward duty 0x40, cmd 0x0002_0030 -> RAMPDN with 64->48->32->16->0, then BRAKE with ctrl_o 0x0003_0000 held exactly 8 cycles, then dir 10 ramping to 0x30.
REQ-036 The bench SHALL cover: at forward duty 0x25, cmd 0x0001_0020 -> one tick to 0x20 with no overshoot; then cmd 0x0001_00FF -> ramp ending exactly at 0xFF.
REQ-037 The bench SHALL cover: in RAMPDN at duty 32, cmd back to 0x0001_0040 -> RUN next cycle, ramp 32->48->64, and no BRAKE entered.
REQ-038 The bench SHALL cover: with MOTOR_WATCHDOG_EN, 200 silent cycles at forward duty 0x40 -> wdt_trip_o=1 and ramp down to ctrl_o 0x0000_0000; the next cmd clears wdt_trip_o.
REQ-039 The bench SHALL cover: rst_ni pulsed low during BRAKE -> ctrl_o 0 and state_o 0 asynchronously, with no ctrl_we_o pulse afterwards.
